pipe_hazard_ctrl: RTL and testbench

Central hazard controller for the 5-stage pipeline.
- Generates stall/flush/bubble controls for the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.
- Selects EXE operand forwarding sources.
- Sequences data-memory accesses in MEM with a req/ack handshake and a timeout.
- Sits beside the stage registers; consumes their control/address fields.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 16 +
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/pipe_hazard_ctrl_fwd_unit.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional performance counters are enabled with HAZ_PERF_CNT_EN (see pipe_hazard_ctrl.sv).
package pipe_hazard_ctrl_pkg;

   typedef enum logic [0:0] {
      S_RUN  = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Stage-register fields in, hazard controls out. The pipeline side is the master,
// the controller the slave. dmem_req/dmem_ack form a req/ack pair: an access completes
// in the cycle where dmem_req and dmem_ack are both high.
interface pipe_hazard_ctrl_if;
   logic [4:0] rs_id, rt_id;
   logic       use_rs_id, use_rt_id;
   logic [4:0] rs_exe, rt_exe;
   logic       wrf_exe, wdc_exe;
   logic [4:0] wa_exe;
   logic       branch_taken_exe;
   logic       wrf_mem, wdc_mem, wdmem_mem;
   logic [4:0] wa_mem;
   logic       wrf_wb;
   logic [4:0] wa_wb;
   logic       dmem_ack;

   logic       dmem_req;
   logic       stall_pc, stall_if_id, stall_id_exe, stall_exe_mem;
   logic       flush_if_id, flush_id_exe;
   logic       bubble_mem_wb;
   logic [1:0] fwd_a, fwd_b;
   logic       mem_timeout;

   modport master (
      output rs_id, rt_id, use_rs_id, use_rt_id, rs_exe, rt_exe, wrf_exe, wdc_exe,
             wa_exe, branch_taken_exe, wrf_mem, wdc_mem, wdmem_mem, wa_mem, wrf_wb,
             wa_wb, dmem_ack,
      input  dmem_req, stall_pc, stall_if_id, stall_id_exe, stall_exe_mem,
             flush_if_id, flush_id_exe, bubble_mem_wb, fwd_a, fwd_b, mem_timeout
   );

   modport slave (
      input  rs_id, rt_id, use_rs_id, use_rt_id, rs_exe, rt_exe, wrf_exe, wdc_exe,
             wa_exe, branch_taken_exe, wrf_mem, wdc_mem, wdmem_mem, wa_mem, wrf_wb,
             wa_wb, dmem_ack,
      output dmem_req, stall_pc, stall_if_id, stall_id_exe, stall_exe_mem,
             flush_if_id, flush_id_exe, bubble_mem_wb, fwd_a, fwd_b, mem_timeout
   );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Combinational operand-forwarding selector for one EXE source register.
module fwd_unit
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [4:0] src_i,
   input  logic       wrf_mem_i,
   input  logic       wdc_mem_i,
   input  logic [4:0] wa_mem_i,
   input  logic       wrf_wb_i,
   input  logic [4:0] wa_wb_i,
   output logic [1:0] sel_o
);

   // A load in MEM has no data yet, so only ALU results forward from MEM.
   always_comb begin
      sel_o = FWD_RF;
      if (src_i != REG_ZERO) begin
         if (wrf_mem_i && !wdc_mem_i && (wa_mem_i == src_i)) sel_o = FWD_MEM;
         else if (wrf_wb_i && (wa_wb_i == src_i))           sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/bubble generation, forwarding and MEM access sequencing.
// Define HAZ_PERF_CNT_EN to add saturating stall/flush/load-use event counters.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int TO_W        = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pipe_hazard_ctrl_if.slave      hz,
   output state_t                 state_o
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0]            stall_cycles_o,
   output logic [31:0]            flush_events_o,
   output logic [31:0]            lu_stalls_o
`endif
);

   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

   state_t          state_q, state_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            timeout_q, timeout_d;

   logic            mem_op, load_use;
   logic            req, stall_all, lu_stall, br_flush, hazards_live;
   logic [1:0]      fwd_a_raw, fwd_b_raw;

   assign mem_op   = hz.wdc_mem | hz.wdmem_mem;
   assign load_use = hz.wrf_exe && hz.wdc_exe && (hz.wa_exe != REG_ZERO) &&
                     ((hz.use_rs_id && (hz.rs_id == hz.wa_exe)) ||
                      (hz.use_rt_id && (hz.rt_id == hz.wa_exe)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_RUN;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // hazards_live marks cycles where the pipeline advances; a branch held during
   // a memory wait is flushed in the cycle the wait ends.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      timeout_d    = timeout_q;
      req          = 1'b0;
      stall_all    = 1'b0;
      lu_stall     = 1'b0;
      br_flush     = 1'b0;
      hazards_live = 1'b0;
      unique case (state_q)
         S_RUN: begin
            req = mem_op;
            if (mem_op && !hz.dmem_ack) begin
               state_d   = S_WAIT;
               cnt_d     = TO_W'(1);
               stall_all = 1'b1;
            end else begin
               hazards_live = 1'b1;
            end
         end
         S_WAIT: begin
            req = 1'b1;
            if (hz.dmem_ack) begin
               state_d      = S_RUN;
               cnt_d        = '0;
               hazards_live = 1'b1;
            end else if (cnt_q == TO_LIMIT) begin
               req          = 1'b0;
               timeout_d    = 1'b1;
               state_d      = S_RUN;
               cnt_d        = '0;
               hazards_live = 1'b1;
            end else begin
               cnt_d     = cnt_q + 1'b1;
               stall_all = 1'b1;
            end
         end
      endcase
      if (hazards_live) begin
         if (hz.branch_taken_exe) br_flush = 1'b1;
         else if (load_use)       lu_stall = 1'b1;
      end
   end

   fwd_unit u_fwd_a (
      .src_i     (hz.rs_exe),
      .wrf_mem_i (hz.wrf_mem),
      .wdc_mem_i (hz.wdc_mem),
      .wa_mem_i  (hz.wa_mem),
      .wrf_wb_i  (hz.wrf_wb),
      .wa_wb_i   (hz.wa_wb),
      .sel_o     (fwd_a_raw)
   );

   fwd_unit u_fwd_b (
      .src_i     (hz.rt_exe),
      .wrf_mem_i (hz.wrf_mem),
      .wdc_mem_i (hz.wdc_mem),
      .wa_mem_i  (hz.wa_mem),
      .wrf_wb_i  (hz.wrf_wb),
      .wa_wb_i   (hz.wa_wb),
      .sel_o     (fwd_b_raw)
   );

   // Every output is forced low while reset is held, including the combinational ones.
   assign hz.dmem_req      = rst_n & req;
   assign hz.stall_pc      = rst_n & (stall_all | lu_stall);
   assign hz.stall_if_id   = rst_n & (stall_all | lu_stall);
   assign hz.stall_id_exe  = rst_n & stall_all;
   assign hz.stall_exe_mem = rst_n & stall_all;
   assign hz.flush_if_id   = rst_n & br_flush;
   assign hz.flush_id_exe  = rst_n & (br_flush | lu_stall);
   assign hz.bubble_mem_wb = rst_n & stall_all;
   assign hz.fwd_a         = rst_n ? fwd_a_raw : FWD_RF;
   assign hz.fwd_b         = rst_n ? fwd_b_raw : FWD_RF;
   assign hz.mem_timeout   = rst_n & timeout_q;
   assign state_o          = state_q;

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q, lu_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         lu_cnt_q    <= '0;
      end else begin
         if (stall_all && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (br_flush  && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
         if (lu_stall  && (lu_cnt_q    != '1)) lu_cnt_q    <= lu_cnt_q + 32'd1;
      end
   end

   assign stall_cycles_o = stall_cnt_q;
   assign flush_events_o = flush_cnt_q;
   assign lu_stalls_o    = lu_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, multi-cycle sequences and random traffic
// checked against a transaction-level reference model.
module tb_pipe_hazard_ctrl;
   import pipe_hazard_ctrl_pkg::*;

   localparam int TO = 4;

   typedef struct packed {
      logic [4:0] rs_id, rt_id;
      logic       use_rs_id, use_rt_id;
      logic [4:0] rs_exe, rt_exe;
      logic       wrf_exe, wdc_exe;
      logic [4:0] wa_exe;
      logic       br;
      logic       wrf_mem, wdc_mem, wdmem_mem;
      logic [4:0] wa_mem;
      logic       wrf_wb;
      logic [4:0] wa_wb;
      logic       ack;
   } in_t;

   typedef struct packed {
      in_t         stim;
      logic [12:0] exp;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic   clk   = 1'b0;
   logic   rst_n = 1'b0;
   state_t state;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if hz();

   pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .TO_W(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .hz      (hz),
      .state_o (state)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: age of the outstanding memory access (0 = first cycle) and the sticky flag.
   int          m_age = 0;
   bit          m_to  = 1'b0;
   logic [12:0] exp_q[$];

   function automatic logic [12:0] ov(input bit req, spc, sif, sie, sem, fif, fie, bub,
                                      input bit [1:0] fa, fb, input bit to);
      return {req, spc, sif, sie, sem, fif, fie, bub, fa, fb, to};
   endfunction

   function automatic logic [12:0] outs();
      return {hz.dmem_req, hz.stall_pc, hz.stall_if_id, hz.stall_id_exe, hz.stall_exe_mem,
              hz.flush_if_id, hz.flush_id_exe, hz.bubble_mem_wb, hz.fwd_a, hz.fwd_b,
              hz.mem_timeout};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input in_t v);
      hz.rs_id            = v.rs_id;
      hz.rt_id            = v.rt_id;
      hz.use_rs_id        = v.use_rs_id;
      hz.use_rt_id        = v.use_rt_id;
      hz.rs_exe           = v.rs_exe;
      hz.rt_exe           = v.rt_exe;
      hz.wrf_exe          = v.wrf_exe;
      hz.wdc_exe          = v.wdc_exe;
      hz.wa_exe           = v.wa_exe;
      hz.branch_taken_exe = v.br;
      hz.wrf_mem          = v.wrf_mem;
      hz.wdc_mem          = v.wdc_mem;
      hz.wdmem_mem        = v.wdmem_mem;
      hz.wa_mem           = v.wa_mem;
      hz.wrf_wb           = v.wrf_wb;
      hz.wa_wb            = v.wa_wb;
      hz.dmem_ack         = v.ack;
   endtask

   task automatic chk(input string nm, input logic [12:0] got, input logic [12:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%b want=%b (req spc sif sie sem fif fie bub fa fb to)",
                  nm, got, exp);
      end
   endtask

   task automatic chk_state(input string nm, input state_t want);
      total++;
      if (state !== want) begin
         bad++;
         $display("FAIL %s state got=%0d want=%0d", nm, state, want);
      end
   endtask

   // Drive at the falling edge, compare 2 ns later, well before the next rising edge.
   task automatic step(input string nm, input in_t v, input logic [12:0] exp);
      @(negedge clk);
      drive(v);
      #2;
      chk(nm, outs(), exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive('0);
      rst_n = 1'b0;
      #2;
      chk("reset_outs", outs(), '0);
      chk_state("reset_state", S_RUN);
      @(negedge clk);
      rst_n = 1'b1;
      m_age = 0;
      m_to  = 1'b0;
   endtask

   // ---------------- reference model ----------------
   function automatic logic [1:0] ref_fwd(input in_t v, input logic [4:0] src);
      if (src == 5'd0) return 2'b00;
      if (v.wrf_mem && !v.wdc_mem && v.wa_mem == src) return 2'b01;
      if (v.wrf_wb && v.wa_wb == src) return 2'b10;
      return 2'b00;
   endfunction

   task automatic model_eval(input in_t v, output logic [12:0] e, output state_t st);
      bit in_acc, ends_to, holding, lu_hz, lu, brf;
      in_acc  = (m_age > 0) || v.wdc_mem || v.wdmem_mem;
      ends_to = in_acc && !v.ack && (m_age == TO);
      holding = in_acc && !v.ack && !ends_to;
      lu_hz   = v.wrf_exe && v.wdc_exe && (v.wa_exe != 5'd0) &&
                ((v.use_rs_id && v.rs_id == v.wa_exe) || (v.use_rt_id && v.rt_id == v.wa_exe));
      brf     = !holding && v.br;
      lu      = !holding && !v.br && lu_hz;
      e  = ov(in_acc && !ends_to, holding || lu, holding || lu, holding, holding,
              brf, brf || lu, holding, ref_fwd(v, v.rs_exe), ref_fwd(v, v.rt_exe), m_to);
      st = (m_age > 0) ? S_WAIT : S_RUN;
      m_age = holding ? m_age + 1 : 0;
      m_to  = m_to | ends_to;
   endtask

   function automatic in_t rnd_in();
      in_t v;
      v.rs_id     = 5'($urandom_range(0, 3));
      v.rt_id     = 5'($urandom_range(0, 3));
      v.use_rs_id = 1'($urandom_range(0, 1));
      v.use_rt_id = 1'($urandom_range(0, 1));
      v.rs_exe    = 5'($urandom_range(0, 3));
      v.rt_exe    = 5'($urandom_range(0, 3));
      v.wrf_exe   = 1'($urandom_range(0, 1));
      v.wdc_exe   = 1'($urandom_range(0, 1));
      v.wa_exe    = 5'($urandom_range(0, 3));
      v.br        = ($urandom_range(0, 5) == 0);
      v.wrf_mem   = 1'($urandom_range(0, 1));
      v.wdc_mem   = ($urandom_range(0, 5) == 0);
      v.wdmem_mem = ($urandom_range(0, 7) == 0);
      v.wa_mem    = 5'($urandom_range(0, 3));
      v.wrf_wb    = 1'($urandom_range(0, 1));
      v.wa_wb     = 5'($urandom_range(0, 3));
      v.ack       = ($urandom_range(0, 2) == 0);
      return v;
   endfunction

   // ---------------- test ----------------
   initial begin
      vec_t        tbl[$];
      in_t         v, ld;
      logic [12:0] e, e2;
      logic [12:0] stall_set;
      state_t      st;

      stall_set = ov(1, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0);
      drive('0);

      // Single-cycle vectors, all applied in S_RUN with no timeout pending.
      v = '0;                                                    tbl.push_back({v, ov(0,0,0,0,0,0,0,0,0,0,0)});
      v = '0; v.wrf_exe=1; v.wdc_exe=1; v.wa_exe=5; v.use_rs_id=1; v.rs_id=5;
                                                                 tbl.push_back({v, ov(0,1,1,0,0,0,1,0,0,0,0)});
      v = '0; v.wrf_exe=1; v.wdc_exe=1; v.wa_exe=7; v.use_rt_id=1; v.rt_id=7;
                                                                 tbl.push_back({v, ov(0,1,1,0,0,0,1,0,0,0,0)});
      v = '0; v.wrf_exe=1; v.wdc_exe=1; v.wa_exe=5; v.rs_id=5;   tbl.push_back({v, ov(0,0,0,0,0,0,0,0,0,0,0)});
      v = '0; v.wrf_exe=1; v.wdc_exe=1; v.use_rs_id=1;           tbl.push_back({v, ov(0,0,0,0,0,0,0,0,0,0,0)});
      v = '0; v.wrf_exe=1; v.wa_exe=5; v.use_rs_id=1; v.rs_id=5; tbl.push_back({v, ov(0,0,0,0,0,0,0,0,0,0,0)});
      v = '0; v.br=1;                                            tbl.push_back({v, ov(0,0,0,0,0,1,1,0,0,0,0)});
      v = '0; v.br=1; v.wrf_exe=1; v.wdc_exe=1; v.wa_exe=5; v.use_rs_id=1; v.rs_id=5;
                                                                 tbl.push_back({v, ov(0,0,0,0,0,1,1,0,0,0,0)});
      v = '0; v.wrf_mem=1; v.wa_mem=3; v.rs_exe=3; v.rt_exe=3;   tbl.push_back({v, ov(0,0,0,0,0,0,0,0,1,1,0)});
      v = '0; v.wrf_mem=1; v.wa_mem=0; v.rs_exe=3; v.rt_exe=3;   tbl.push_back({v, ov(0,0,0,0,0,0,0,0,0,0,0)});
      v = '0; v.wrf_wb=1; v.wa_wb=5; v.rs_exe=5; v.rt_exe=6;     tbl.push_back({v, ov(0,0,0,0,0,0,0,0,2,0,0)});
      v = '0; v.wrf_mem=1; v.wa_mem=4; v.wrf_wb=1; v.wa_wb=4; v.rs_exe=4; v.rt_exe=4;
                                                                 tbl.push_back({v, ov(0,0,0,0,0,0,0,0,1,1,0)});
      v = '0; v.wrf_mem=1; v.wdc_mem=1; v.wa_mem=4; v.wrf_wb=1; v.wa_wb=4; v.rs_exe=4; v.rt_exe=4; v.ack=1;
                                                                 tbl.push_back({v, ov(1,0,0,0,0,0,0,0,2,2,0)});
      v = '0; v.wdmem_mem=1; v.ack=1;                            tbl.push_back({v, ov(1,0,0,0,0,0,0,0,0,0,0)});
      v = '0; v.wrf_wb=1; v.wa_wb=0;                             tbl.push_back({v, ov(0,0,0,0,0,0,0,0,0,0,0)});

      do_reset();
      foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i].stim, tbl[i].exp);

      // Load-use stall, then the loaded value forwards from WB.
      do_reset();
      v = '0; v.wrf_exe=1; v.wdc_exe=1; v.wa_exe=5; v.use_rs_id=1; v.rs_id=5;
      step("lu_stall", v, ov(0,1,1,0,0,0,1,0,0,0,0));
      v = '0; v.wrf_wb=1; v.wa_wb=5; v.rs_exe=5;
      step("lu_fwd_wb", v, ov(0,0,0,0,0,0,0,0,2,0,0));

      // Ack after 3 cycles with a branch held in EXE across the wait.
      do_reset();
      ld = '0; ld.wrf_mem=1; ld.wdc_mem=1; ld.wa_mem=5;
      step("wait_entry", ld, stall_set);
      v = ld; v.br = 1;
      step("wait_c1", v, stall_set);
      chk_state("wait_state", S_WAIT);
      step("wait_c2", v, stall_set);
      v.ack = 1;
      step("wait_ack", v, ov(1,0,0,0,0,1,1,0,0,0,0));
      step("wait_after", '0, '0);
      chk_state("wait_exit_state", S_RUN);

      // Timeout: ack never arrives.
      do_reset();
      step("to_entry", ld, stall_set);
      for (int i = 1; i < TO; i++) step($sformatf("to_wait%0d", i), ld, stall_set);
      step("to_abort", ld, '0);
      for (int i = 0; i < 3; i++) begin
         step($sformatf("to_sticky%0d", i), '0, ov(0,0,0,0,0,0,0,0,0,0,1));
         chk_state("to_state", S_RUN);
      end
      do_reset();
      step("to_cleared", '0, '0);

      // Asynchronous reset in the middle of a wait.
      do_reset();
      v = ld; v.wrf_wb=1; v.wa_wb=3; v.rs_exe=3;
      step("ar_entry", v, ov(1,1,1,1,1,0,0,1,2,0,0));
      step("ar_wait", v, ov(1,1,1,1,1,0,0,1,2,0,0));
      chk_state("ar_wait_state", S_WAIT);
      #1 rst_n = 1'b0;
      #1 chk("ar_async_outs", outs(), '0);
      chk_state("ar_async_state", S_RUN);
      @(negedge clk);
      drive('0);
      rst_n = 1'b1;
      #2 chk("ar_release", outs(), '0);
      chk_state("ar_release_state", S_RUN);

      // Random traffic against the reference model.
      for (int n = 0; n < 2000; n++) begin
         if (n % 250 == 0) do_reset();
         v = rnd_in();
         @(negedge clk);
         drive(v);
         #2;
         model_eval(v, e, st);
         exp_q.push_back(e);
         e2 = exp_q.pop_front();
         chk($sformatf("rand%0d", n), outs(), e2);
         chk_state($sformatf("rand_st%0d", n), st);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
